// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Drives the open-drain request-to-send sequence, shifts one byte out on device clocks, checks ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int RTS_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_B = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_B + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [3:0]      n_q, n_d;
  logic [8:0]      frame_q, frame_d;
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [1:0]      clk_sync, data_sync;
  logic            clk_prev;
  logic            fe, data_s, timeout;

  // Idle bus is high, so synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fe      = clk_prev & ~clk_sync[1];
  assign data_s  = data_sync[1];
  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      frame_q   <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      frame_q   <= frame_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    frame_d   = frame_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d = {~^tx_data, tx_data};
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RTS;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RTS: begin
        if (cnt_q == CW'(RTS_CYCLES - 1)) begin
          cnt_d     = '0;
          n_d       = '0;
          data_oe_d = 1'b1;
          state_d   = S_SEND;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_SEND: begin
        // Frame bits 0..8 go out after edges 1..9; edge 10 releases the line for the stop bit.
        if (fe) begin
          cnt_d = '0;
          n_d   = n_q + 4'd1;
          if (n_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~frame_q[n_q];
          end
        end else if (timeout) begin
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ACK: begin
        if (fe) begin
          cnt_d = '0;
          if (data_s) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync[1] && data_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (fe) begin
          cnt_d = '0;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign ps2_data_oe = (state_q == S_RTS) || ((state_q == S_SEND) && data_oe_q);
  assign done        = done_q;
  assign error       = error_q;

endmodule
